// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the host-side run sequencer.
package run_seq_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int TIMEOUT_DEF = 4096;
  localparam int TW_DEF      = 13;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RB_ADDR,
    RB_WAIT,
    RB_OUT,
    FIN
  } state_t;

endpackage

// File: rtl/run_sequencer.sv
// Host-side initiator for the core's start/done run protocol: preload, run, read back.
//   state   | meaning
//   IDLE    | waiting for a job command
//   LOAD    | writing preload words into data memory
//   RUN     | start high, waiting for done or timeout
//   RB_ADDR | present readback address to data memory
//   RB_WAIT | capture read data into the output register
//   RB_OUT  | offer readback word until the consumer takes it
//   FIN     | one closing cycle before returning to IDLE
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_ld_base,
  input  logic [AW-1:0] cmd_ld_len,
  input  logic [AW-1:0] cmd_rb_base,
  input  logic [AW-1:0] cmd_rb_len,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] dm_rdata,
  output logic          start,
  input  logic          done,
  output logic          rb_valid,
  output logic [DW-1:0] rb_data,
  input  logic          rb_ready,
  output logic          busy,
  output logic          timeout_err
);

  localparam logic [TW-1:0] CNT_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_ONE  = TW'(1);
  localparam logic [AW-1:0] ADR_ONE  = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] ld_base_q, ld_len_q, rb_base_q, rb_len_q;
  logic [AW-1:0] i_q, j_q;
  logic [TW-1:0] cnt_q;
  logic          start_q, terr_q;
  logic [DW-1:0] rb_data_q;
  logic          run_first, run_tmo;

  // The run timer counts down from TIMEOUT-1; its load value marks the guard cycle.
  assign run_first = (cnt_q == CNT_LOAD);

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    ld_ready  = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    rb_valid  = 1'b0;
    run_tmo   = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_ld_len != '0) ? LOAD : RUN;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          dm_we    = 1'b1;
          dm_addr  = ld_base_q + i_q;
          dm_wdata = ld_data;
          if ((i_q + ADR_ONE) == ld_len_q) state_d = RUN;
        end
      end
      RUN: begin
        if (!run_first && done) begin
          state_d = (rb_len_q != '0) ? RB_ADDR : FIN;
        end else if (cnt_q == '0) begin
          run_tmo = 1'b1;
          state_d = FIN;
        end
      end
      RB_ADDR: begin
        dm_addr = rb_base_q + j_q;
        state_d = RB_WAIT;
      end
      RB_WAIT: state_d = RB_OUT;
      RB_OUT: begin
        rb_valid = 1'b1;
        if (rb_ready) state_d = ((j_q + ADR_ONE) == rb_len_q) ? FIN : RB_ADDR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_base_q <= '0;
      ld_len_q  <= '0;
      rb_base_q <= '0;
      rb_len_q  <= '0;
      i_q       <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      terr_q    <= 1'b0;
      rb_data_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= (state_d == RUN);
      if (state_q != RUN && state_d == RUN) cnt_q <= CNT_LOAD;
      else if (state_q == RUN && cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
      case (state_q)
        IDLE: if (cmd_valid) begin
          ld_base_q <= cmd_ld_base;
          ld_len_q  <= cmd_ld_len;
          rb_base_q <= cmd_rb_base;
          rb_len_q  <= cmd_rb_len;
          i_q       <= '0;
          j_q       <= '0;
          terr_q    <= 1'b0;
        end
        LOAD:    if (ld_valid) i_q <= i_q + ADR_ONE;
        RUN:     if (run_tmo) terr_q <= 1'b1;
        RB_WAIT: rb_data_q <= dm_rdata;
        RB_OUT:  if (rb_ready) j_q <= j_q + ADR_ONE;
        default: ;
      endcase
    end
  end

  assign start       = start_q;
  assign timeout_err = terr_q;
  assign rb_data     = rb_data_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: directed and random jobs against a job-level model.
module tb_run_sequencer;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_ld_base = '0, cmd_ld_len = '0, cmd_rb_base = '0, cmd_rb_len = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          start;
  logic          done = 1'b0;
  logic          rb_valid;
  logic [DW-1:0] rb_data;
  logic          rb_ready = 1'b0;
  logic          busy;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  always #5 clk = ~clk;

  run_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ld_base(cmd_ld_base), .cmd_ld_len(cmd_ld_len),
    .cmd_rb_base(cmd_rb_base), .cmd_rb_len(cmd_rb_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .start(start), .done(done),
    .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  function automatic logic [DW-1:0] init_word(input int k);
    return DW'((k * 37) ^ 8'h5A);
  endfunction

  // Data memory: synchronous write, one-cycle read latency; reset restores a known pattern.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
    end else if (dm_we) begin
      mem[dm_addr] <= dm_wdata;
    end
    dm_rdata <= mem[dm_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_reset();
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
  endtask

  // One complete job. done rises on RUN cycle done_at (counted from 1) and stays high;
  // rb_mode 1 holds rb_ready low for 7 cycles per word; abort_at>0 pulses rst on that RUN cycle.
  task automatic run_job(input logic [7:0] lb, input logic [7:0] ll, input logic [7:0] rbb,
                         input logic [7:0] rbl, input int done_at, input int ld_pct,
                         input int rb_mode, input int abort_at);
    int            wr, rd, run_cnt, rises, hold, cyc;
    logic          prev_start, stable_valid, exp_to;
    logic [DW-1:0] stable_data;
    logic [7:0]    a;
    int            exp_run, exp_rb;
    wr = 0; rd = 0; run_cnt = 0; rises = 0; hold = 0; cyc = 0;
    prev_start = 1'b0; stable_valid = 1'b0; stable_data = '0;
    exp_to  = (done_at > TMO);
    exp_run = exp_to ? TMO : ((done_at < 2) ? 2 : done_at);
    exp_rb  = exp_to ? 0 : int'(rbl);

    cmd_ld_base = lb; cmd_ld_len = ll; cmd_rb_base = rbb; cmd_rb_len = rbl;
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("terr_cleared_on_accept", timeout_err, 0);

    while (cyc < 3000) begin
      if (start) run_cnt++;
      if (start && !prev_start) rises++;
      prev_start = start;
      if (abort_at > 0 && run_cnt == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        done = 1'b0;
        ref_reset();
        chk("abort_start", start, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_terr", timeout_err, 0);
        chk("abort_rb_valid", rb_valid, 0);
        return;
      end
      done     = start && (run_cnt >= done_at);
      ld_valid = ($urandom_range(99) < ld_pct);
      ld_data  = DW'($urandom);
      rb_ready = rb_mode != 0 ? (hold >= 7) : 1'($urandom_range(1));
      #1;
      if (dm_we) begin
        a = lb + 8'(wr);
        chk("wr_addr", dm_addr, a);
        chk("wr_data", dm_wdata, ld_data);
        chk("wr_handshake", {ld_valid, ld_ready}, 2'b11);
        ref_mem[a] = ld_data;
        wr++;
      end
      if (start) begin
        chk("run_no_we", dm_we, 0);
        chk("run_addr_zero", dm_addr, 0);
      end
      if (stable_valid) begin
        chk("rb_valid_held", rb_valid, 1);
        chk("rb_data_stable", rb_data, stable_data);
      end
      if (rb_valid && rb_ready) begin
        a = rbb + 8'(rd);
        chk("rb_data", rb_data, ref_mem[a]);
        rd++;
        stable_valid = 1'b0;
        hold = 0;
      end else if (rb_valid) begin
        stable_valid = 1'b1;
        stable_data  = rb_data;
        hold++;
      end
      if (!busy) break;
      tick();
      cyc++;
    end
    if (cyc >= 3000) chk("job_cycle_budget", 0, 1);
    ld_valid = 1'b0; rb_ready = 1'b0; done = 1'b0;
    chk("write_count", wr, ll);
    chk("run_length", run_cnt, exp_run);
    chk("start_single_pulse", rises, 1);
    chk("readback_count", rd, exp_rb);
    chk("timeout_err", timeout_err, exp_to);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_start_low", start, 0);
  endtask

  initial begin
    ref_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ld_ready", ld_ready, 0);
    rst = 1'b0;
    tick();

    run_job(8'h10, 8'd3, 8'h20, 8'd2, 11, 100, 0, 0);   // basic job
    run_job(8'h40, 8'd0, 8'h50, 8'd0, 6, 100, 0, 0);    // zero-length phases
    run_job(8'hFE, 8'd3, 8'hFE, 8'd3, 0, 100, 0, 0);    // guard cycle, address wrap
    run_job(8'h30, 8'd2, 8'h30, 8'd4, 1000, 100, 0, 0); // timeout, no readback
    run_job(8'h60, 8'd1, 8'h60, 8'd1, TMO, 100, 0, 0);  // done on final cycle wins
    run_job(8'h70, 8'd5, 8'h70, 8'd5, 4, 50, 1, 0);     // backpressure both sides
    for (int n = 0; n < 6; n++) begin
      run_job(8'($urandom), 8'($urandom_range(8)), 8'($urandom), 8'($urandom_range(6)),
              int'($urandom_range(20)), int'($urandom_range(100, 30)), 0, 0);
    end
    run_job(8'h80, 8'd2, 8'h80, 8'd2, 1000, 100, 0, 5); // reset mid-RUN
    tick();
    run_job(8'h80, 8'd2, 8'h80, 8'd2, 3, 100, 0, 0);    // recovery after abort

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
